// File: rtl/sobel_config_pkg.sv
// Shared widths, types and simulation file locations for the Sobel stream engine.
// Gradients carry three extra bits; the magnitude |Gx|+|Gy| carries four.
package sobel_config_pkg;

  localparam int PIX_W  = 8;
  localparam int GRAD_W = PIX_W + 3;
  localparam int MAG_W  = PIX_W + 4;

  typedef logic        [PIX_W-1:0]  pixel_t;
  typedef logic signed [GRAD_W-1:0] grad_t;
  typedef logic        [MAG_W-1:0]  mag_t;

  typedef enum logic {
    MODE_BINARY = 1'b0,
    MODE_MAG    = 1'b1
  } out_mode_e;

  // Image files used by the simulation harness around the engine
  localparam string SIM_INPUT_PATH  = "sim/image_in.txt";
  localparam string SIM_OUTPUT_PATH = "sim/edge_out.txt";

endpackage

// File: rtl/sobel_line_buffer.sv
// Enabled delay line: dout_o is the sample written DEPTH enabled cycles earlier.
// One instance holds one image line of the Sobel window.
module sobel_line_buffer
  import sobel_config_pkg::*;
#(
  parameter int DEPTH = 5,
  parameter int WIDTH = PIX_W
) (
  input  logic             clk_i,
  input  logic             en_i,
  input  logic [WIDTH-1:0] din_i,
  output logic [WIDTH-1:0] dout_o
);

  logic [WIDTH-1:0] r_mem [DEPTH];

  always_ff @(posedge clk_i) begin
    if (en_i) begin
      r_mem[0] <= din_i;
      for (int i = 1; i < DEPTH; i++) begin
        r_mem[i] <= r_mem[i-1];
      end
    end
  end

  assign dout_o = r_mem[DEPTH-1];

endmodule

// File: rtl/sobel_stream_engine.sv
// Streaming 3x3 Sobel engine: raster pixels in, one result per interior pixel out.
// Stage 1 builds the window from two line buffers; stage 2 computes and registers the result.
module sobel_stream_engine #(
  parameter int IMAGE_ROW_SIZE    = 5,
  parameter int IMAGE_COLUMN_SIZE = 5,
  parameter int PIX_W             = sobel_config_pkg::PIX_W,
  parameter int THRESHOLD         = 100
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             pix_valid_i,
  output logic             pix_ready_o,
  input  logic [PIX_W-1:0] pix_data_i,
  input  logic             pix_sof_i,
  input  logic             thresh_we_i,
  input  logic [PIX_W+3:0] thresh_i,
  input  logic             mode_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [PIX_W-1:0] out_data_o,
  output logic             out_eof_o,
  output logic             frame_err_o
);
  import sobel_config_pkg::*;

  localparam int GW = PIX_W + 3;
  localparam int MW = PIX_W + 4;
  localparam int RW = $clog2(IMAGE_ROW_SIZE);
  localparam int CW = $clog2(IMAGE_COLUMN_SIZE);
  localparam logic [MW-1:0] L_PIX_MAX = {4'b0000, {PIX_W{1'b1}}};

  logic             w_stall, w_accept;
  logic [RW-1:0]    r_row, w_row_cur;
  logic [CW-1:0]    r_col, w_col_cur;
  logic             r_frame_err;
  logic [PIX_W-1:0] r_win [3][3];
  logic [PIX_W-1:0] w_lb0_q, w_lb1_q;
  logic             r_s1_valid, r_s1_eof;
  logic [MW-1:0]    r_thresh;
  logic             r_out_valid, r_out_eof;
  logic [PIX_W-1:0] r_out_data;

  // One stall term freezes both stages while a result waits at the output
  assign w_stall     = r_out_valid && !out_ready_i;
  assign pix_ready_o = !w_stall;
  assign w_accept    = pix_valid_i && !w_stall;
  assign w_row_cur   = pix_sof_i ? '0 : r_row;
  assign w_col_cur   = pix_sof_i ? '0 : r_col;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_row       <= '0;
      r_col       <= '0;
      r_frame_err <= 1'b0;
    end else if (w_accept) begin
      if (pix_sof_i && (r_row != '0 || r_col != '0)) r_frame_err <= 1'b1;
      if (w_col_cur == CW'(IMAGE_COLUMN_SIZE-1)) begin
        r_col <= '0;
        r_row <= (w_row_cur == RW'(IMAGE_ROW_SIZE-1)) ? '0 : w_row_cur + 1'b1;
      end else begin
        r_col <= w_col_cur + 1'b1;
        r_row <= w_row_cur;
      end
    end
  end

  sobel_line_buffer #(.DEPTH(IMAGE_COLUMN_SIZE), .WIDTH(PIX_W)) u_line0 (
    .clk_i  (clk_i),
    .en_i   (w_accept),
    .din_i  (pix_data_i),
    .dout_o (w_lb0_q)
  );

  sobel_line_buffer #(.DEPTH(IMAGE_COLUMN_SIZE), .WIDTH(PIX_W)) u_line1 (
    .clk_i  (clk_i),
    .en_i   (w_accept),
    .din_i  (w_lb0_q),
    .dout_o (w_lb1_q)
  );

  always_ff @(posedge clk_i) begin
    if (w_accept) begin
      for (int r = 0; r < 3; r++) begin
        r_win[r][0] <= r_win[r][1];
        r_win[r][1] <= r_win[r][2];
      end
      r_win[0][2] <= w_lb1_q;
      r_win[1][2] <= w_lb0_q;
      r_win[2][2] <= pix_data_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_s1_valid <= 1'b0;
      r_s1_eof   <= 1'b0;
    end else if (!w_stall) begin
      r_s1_valid <= w_accept && (w_row_cur >= RW'(2)) && (w_col_cur >= CW'(2));
      r_s1_eof   <= (w_row_cur == RW'(IMAGE_ROW_SIZE-1)) &&
                    (w_col_cur == CW'(IMAGE_COLUMN_SIZE-1));
    end
  end

  logic [PIX_W+1:0] w_gx_pos, w_gx_neg, w_gy_pos, w_gy_neg;
  logic signed [GW-1:0] w_gx, w_gy;
  logic [GW-1:0]    w_ax, w_ay;
  logic [MW-1:0]    w_mag;
  logic [PIX_W-1:0] w_result;

  always_comb begin
    w_gx_pos = {2'b00, r_win[0][2]} + {1'b0, r_win[1][2], 1'b0} + {2'b00, r_win[2][2]};
    w_gx_neg = {2'b00, r_win[0][0]} + {1'b0, r_win[1][0], 1'b0} + {2'b00, r_win[2][0]};
    w_gy_pos = {2'b00, r_win[2][0]} + {1'b0, r_win[2][1], 1'b0} + {2'b00, r_win[2][2]};
    w_gy_neg = {2'b00, r_win[0][0]} + {1'b0, r_win[0][1], 1'b0} + {2'b00, r_win[0][2]};
    w_gx     = $signed({1'b0, w_gx_pos}) - $signed({1'b0, w_gx_neg});
    w_gy     = $signed({1'b0, w_gy_pos}) - $signed({1'b0, w_gy_neg});
    w_ax     = w_gx[GW-1] ? $unsigned(-w_gx) : $unsigned(w_gx);
    w_ay     = w_gy[GW-1] ? $unsigned(-w_gy) : $unsigned(w_gy);
    w_mag    = {1'b0, w_ax} + {1'b0, w_ay};
    w_result = '0;
    if (out_mode_e'(mode_i) == MODE_MAG) begin
      w_result = (w_mag > L_PIX_MAX) ? '1 : w_mag[PIX_W-1:0];
    end else begin
      w_result = (w_mag > r_thresh) ? '1 : '0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_thresh <= MW'(THRESHOLD);
    end else if (thresh_we_i) begin
      r_thresh <= thresh_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_eof   <= 1'b0;
    end else if (!w_stall) begin
      r_out_valid <= r_s1_valid;
      r_out_eof   <= r_s1_valid && r_s1_eof;
      if (r_s1_valid) r_out_data <= w_result;
    end
  end

  assign out_valid_o = r_out_valid;
  assign out_data_o  = r_out_data;
  assign out_eof_o   = r_out_eof;
  assign frame_err_o = r_frame_err;

endmodule
